// File: rtl/wb_dpbram_slave.sv
// rtl/wb_dpbram_slave.sv - Wishbone B4 pipelined slave front-end for a dual-port block RAM
//
// Ports:
//   i_clk, i_reset        clock (rising edge), asynchronous active-high reset
//   i_wb_cyc/stb/we       bus cycle, strobe, write (1) / read (0)
//   i_wb_addr/data/sel    word address, write data, byte selects
//   o_wb_stall            high while a partial write's read-modify-write is in progress
//   o_wb_ack/o_wb_data    registered acknowledge and read data, two edges after accept
//   o_enA/o_weA/o_addrA/o_dinA   RAM write port A
//   o_enB/o_addrB/i_doutB        RAM registered read port B
module wb_dpbram_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_wb_cyc,
    input  logic                    i_wb_stb,
    input  logic                    i_wb_we,
    input  logic [ADDR_WIDTH-1:0]   i_wb_addr,
    input  logic [DATA_WIDTH-1:0]   i_wb_data,
    input  logic [DATA_WIDTH/8-1:0] i_wb_sel,
    output logic                    o_wb_stall,
    output logic                    o_wb_ack,
    output logic [DATA_WIDTH-1:0]   o_wb_data,
    output logic                    o_enA,
    output logic                    o_weA,
    output logic [ADDR_WIDTH-1:0]   o_addrA,
    output logic [DATA_WIDTH-1:0]   o_dinA,
    output logic                    o_enB,
    output logic [ADDR_WIDTH-1:0]   o_addrB,
    input  logic [DATA_WIDTH-1:0]   i_doutB
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   rmw_addr;
    logic [DATA_WIDTH-1:0]   rmw_data;
    logic [SEL_WIDTH-1:0]    rmw_sel;
    logic                    s1_valid;
    logic                    s1_we;

    logic                    accept;
    logic                    sel_full;
    logic                    sel_none;
    logic                    partial;
    logic [DATA_WIDTH-1:0]   merged;

    assign o_wb_stall = (state == RMW);
    assign accept     = i_wb_cyc & i_wb_stb & (state == IDLE);
    assign sel_full   = &i_wb_sel;
    assign sel_none   = ~|i_wb_sel;
    assign partial    = accept & i_wb_we & ~sel_full & ~sel_none;

    // Unselected bytes come from the old word, read through port B at the accept edge.
    always_comb begin
        merged = i_doutB;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            if (rmw_sel[i]) begin
                merged[i*8 +: 8] = rmw_data[i*8 +: 8];
            end
        end
    end

    // RAM ports are driven combinationally so the RAM samples them at the accept edge.
    always_comb begin
        o_enA   = 1'b0;
        o_weA   = 1'b0;
        o_addrA = i_wb_addr;
        o_dinA  = i_wb_data;
        o_enB   = 1'b0;
        o_addrB = i_wb_addr;
        if (i_reset) begin
            o_enA = 1'b0;
            o_weA = 1'b0;
            o_enB = 1'b0;
        end else if (state == RMW) begin
            o_enA   = 1'b1;
            o_weA   = 1'b1;
            o_addrA = rmw_addr;
            o_dinA  = merged;
        end else if (accept) begin
            if (!i_wb_we) begin
                o_enB = 1'b1;
            end else if (sel_full) begin
                o_enA = 1'b1;
                o_weA = 1'b1;
            end else if (!sel_none) begin
                o_enB = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            rmw_addr  <= '0;
            rmw_data  <= '0;
            rmw_sel   <= '0;
            s1_valid  <= 1'b0;
            s1_we     <= 1'b0;
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (partial) begin
                        rmw_addr <= i_wb_addr;
                        rmw_data <= i_wb_data;
                        rmw_sel  <= i_wb_sel;
                        state    <= RMW;
                    end
                end
                RMW: begin
                    // The merged write completes at this edge even if the cycle was dropped.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Dropping cyc abandons everything in flight, so no stale ack leaks out.
            if (!i_wb_cyc) begin
                s1_valid <= 1'b0;
                s1_we    <= 1'b0;
                o_wb_ack <= 1'b0;
            end else begin
                s1_valid <= accept;
                s1_we    <= i_wb_we;
                o_wb_ack <= s1_valid;
                // Read data is taken one edge after accept, before any RMW reuses port B.
                if (s1_valid && !s1_we) begin
                    o_wb_data <= i_doutB;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_dpbram_slave.sv
// tb/tb_wb_dpbram_slave.sv - directed self-checking bench for wb_dpbram_slave
module tb_wb_dpbram_slave;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cyc, stb, we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        stall, ack;
    logic [31:0] rdata;
    logic        en_a, we_a, en_b;
    logic [9:0]  addr_a, addr_b;
    logic [31:0] din_a;
    logic [31:0] dout_b;

    logic [31:0] mem [0:1023];
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;

    int checks   = 0;
    int failures = 0;
    int ena_count = 0;

    wb_dpbram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .i_wb_sel   (sel),
        .o_wb_stall (stall),
        .o_wb_ack   (ack),
        .o_wb_data  (rdata),
        .o_enA      (en_a),
        .o_weA      (we_a),
        .o_addrA    (addr_a),
        .o_dinA     (din_a),
        .o_enB      (en_b),
        .o_addrB    (addr_b),
        .i_doutB    (dout_b)
    );

    // Behavioural block RAM: write port A, registered read port B (read-first).
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (en_a && we_a) mem[addr_a] <= din_a;
        if (en_b) dout_b <= mem[addr_b];
    end

    always @(negedge clk) if (en_a === 1'b1) ena_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // One request; ack must be low after the accept edge and high after the next one.
    task automatic bus_op(input logic w, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] s, input string tag,
                          input logic chk_data, input logic [31:0] exp_data);
        logic part;
        part = w && (s != 4'hF) && (s != 4'h0);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        check({tag, "_stall_pre"}, {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
        check({tag, "_stall_post"}, {31'd0, stall}, {31'd0, part});
        check({tag, "_ack_early"}, {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_ack"}, {31'd0, ack}, 32'd1);
        if (chk_data) check({tag, "_data"}, rdata, exp_data);
        @(posedge clk); #1;
        check({tag, "_ack_once"}, {31'd0, ack}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 10'h005;
        wdata = 32'h0; sel = 4'hF; pre_we = 1'b0; pre_addr = 10'h0; pre_data = 32'h0;
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_data", rdata, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_enB_forced", {31'd0, en_b}, 32'd0);
        we = 1'b1;
        #1;
        check("rst_enA_forced", {31'd0, en_a}, 32'd0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Full write then read back
        bus_op(1'b1, 10'h005, 32'hDEADBEEF, 4'hF, "wr_full", 1'b0, 32'h0);
        bus_op(1'b0, 10'h005, 32'h0, 4'hF, "rd_full", 1'b1, 32'hDEADBEEF);

        // Back-to-back reads
        preload(10'h000, 32'h10);
        preload(10'h001, 32'h11);
        preload(10'h002, 32'h12);
        preload(10'h003, 32'h13);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; addr = 10'h000;
        for (int i = 0; i < 6; i++) begin
            check("b2b_stall", {31'd0, stall}, 32'd0);
            @(posedge clk); #1;
            check("b2b_ack", {31'd0, ack}, {31'd0, (i >= 1 && i <= 4)});
            if (i >= 1 && i <= 4) check("b2b_data", rdata, 32'h10 + 32'(i - 1));
            if (i < 3) addr = 10'(i + 1);
            else stb = 1'b0;
        end

        // Write then immediate read of same address
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 10'h040; wdata = 32'hCAFEF00D; sel = 4'hF;
        @(posedge clk); #1;
        we = 1'b0;
        @(posedge clk); #1;
        stb = 1'b0;
        check("hz_wr_ack", {31'd0, ack}, 32'd1);
        @(posedge clk); #1;
        check("hz_rd_ack", {31'd0, ack}, 32'd1);
        check("hz_rd_data", rdata, 32'hCAFEF00D);
        @(posedge clk); #1;

        // Partial write merge
        preload(10'h020, 32'h11223344);
        bus_op(1'b1, 10'h020, 32'h0000AB00, 4'b0010, "wr_part", 1'b0, 32'h0);
        bus_op(1'b0, 10'h020, 32'h0, 4'hF, "rd_part", 1'b1, 32'h1122AB44);

        // Zero-sel write: acked, no RAM write
        n = ena_count;
        bus_op(1'b1, 10'h020, 32'hFFFFFFFF, 4'b0000, "wr_zero", 1'b0, 32'h0);
        check("zero_no_enA", 32'(ena_count - n), 32'd0);
        bus_op(1'b0, 10'h020, 32'h0, 4'hF, "rd_zero", 1'b1, 32'h1122AB44);

        // Read abandoned by dropping cyc
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 10'h001;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check("abandon_ack1", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        check("abandon_ack2", {31'd0, ack}, 32'd0);
        bus_op(1'b0, 10'h005, 32'h0, 4'hF, "rd_after", 1'b1, 32'hDEADBEEF);

        // Reset during RMW
        preload(10'h030, 32'hA5A5A5A5);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 10'h030; wdata = 32'h000000FF; sel = 4'b0001;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
        check("rmw_stall", {31'd0, stall}, 32'd1);
        check("rmw_enA", {31'd0, en_a}, 32'd1);
        check("rmw_addrA", {22'd0, addr_a}, 32'h030);
        check("rmw_dinA", din_a, 32'hA5A5A5FF);
        rst = 1'b1; cyc = 1'b0;
        #1;
        check("rstrmw_enA", {31'd0, en_a}, 32'd0);
        check("rstrmw_weA", {31'd0, we_a}, 32'd0);
        check("rstrmw_stall", {31'd0, stall}, 32'd0);
        check("rstrmw_ack", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstrmw_ack2", {31'd0, ack}, 32'd0);
        check("rstrmw_mem", mem[10'h030], 32'hA5A5A5A5);
        @(posedge clk); #1;
        bus_op(1'b0, 10'h030, 32'h0, 4'hF, "rd_rstrmw", 1'b1, 32'hA5A5A5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_dpbram_slave.md
# wb_dpbram_slave

Wishbone B4 pipelined slave front-end for the dual-port block RAM. It translates bus reads and writes into the RAM's write port (A) and registered read port (B). Partial-word writes are handled by a single-cycle read-modify-write, since the RAM has no byte enables. It sits directly upstream of the RAM and is the only agent driving its ports.

## Interface

- DATA_WIDTH, 32, bus and RAM word width; must be a multiple of 8.
- ADDR_WIDTH, 10, word address width; the RAM depth is 2^ADDR_WIDTH.

Ports:

- i_clk  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_wb_cyc  in  1  bus cycle valid.
- i_wb_stb  in  1  request strobe.
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_addr  in  ADDR_WIDTH  word address.
- i_wb_data  in  DATA_WIDTH  write data.
- i_wb_sel  in  DATA_WIDTH/8  byte selects.
- o_wb_stall  out  1  slave cannot accept a request this cycle.
- o_wb_ack  out  1  request completed (registered).
- o_wb_data  out  DATA_WIDTH  read data, valid with ack (registered).
- o_enA  out  1  RAM port A enable.
- o_weA  out  1  RAM port A write enable.
- o_addrA  out  ADDR_WIDTH  RAM port A address.
- o_dinA  out  DATA_WIDTH  RAM port A write data.
- o_enB  out  1  RAM port B enable.
- o_addrB  out  ADDR_WIDTH  RAM port B address.
- i_doutB  in  DATA_WIDTH  RAM port B data; valid the cycle after an o_enB edge.

## Operation

- **Acceptance:** a request is accepted at an edge where i_wb_cyc & i_wb_stb & !o_wb_stall. At most one request is accepted per cycle.
- **States:** IDLE and RMW.
  - o_wb_stall = (state == RMW).
- **Read, in IDLE:**
  - o_enB = 1 and o_addrB = i_wb_addr, combinationally.
  - The RAM samples the address at the accept edge.
- **Full write, in IDLE (sel all ones):** o_enA = o_weA = 1, o_addrA = i_wb_addr, o_dinA = i_wb_data, combinationally. The RAM writes at the accept edge.
- **Zero-sel write (sel == 0):** no RAM access. The request is still acknowledged.
- **Partial write (sel neither 0 nor all ones):**
  - In IDLE: o_enB = 1 at addr. At accept, address, data and sel are latched and the state goes to RMW.
  - In RMW: o_enB = 0, o_enA = o_weA = 1, o_addrA = latched address.
  - o_dinA byte i = sel[i] ? latched data byte i : i_doutB byte i.
  - At the next edge the write completes and the state returns to IDLE.
- **Ack pipeline:** 2-stage shift register of accepted requests, plus a we flag.
  - Stage-2 read: o_wb_data <= i_doutB.
  - Stage-2 write: o_wb_data holds its previous value.
  - Acks are returned strictly in acceptance order.
- **RAM port defaults:** all RAM enables are 0 when no request is accepted and the state is not RMW. o_enA/o_weA/o_enB are forced to 0 while i_reset is high.

## Timing

- **Reset values:**
  - o_wb_ack = 0, o_wb_data = 0, o_wb_stall = 0.
  - State = IDLE, ack pipeline cleared.
  - RAM enables = 0.
- **Latency:** every accepted request is acknowledged exactly 2 edges after its accept edge. Ack is high for 1 cycle per request.
- **Throughput:**
  - Reads and full/zero-sel writes: 1 per cycle, no stall.
  - Partial write: stall for exactly 1 cycle.
- **Ordering hazards:**
  - A read accepted the edge after a write to the same address returns the new data, because the RAM write precedes the read edge.
  - A partial write following a write to the same address merges with the updated word.
- **RMW and earlier reads:** the data of a read accepted at edge k-1 is captured at edge k, before the RMW uses i_doutB. There is no corruption.
- **i_wb_cyc deasserted:**
  - The ack pipeline is cleared at that edge, so no ack is issued for abandoned requests.
  - An in-flight RMW still performs its write.
  - Requests seen while cyc = 0 are ignored.
- **i_wb_stb with cyc = 0:** ignored.
- **Reset asserted mid-RMW:** the write is aborted (o_enA low immediately), the state goes to IDLE, and no ack is issued.
- **Address range:** addresses wrap naturally in ADDR_WIDTH bits. There is no error response.

## Test plan

- Full write 0xDEADBEEF to addr 0x005 (sel 4'hF), then read 0x005 → each ack arrives 2 edges after its accept, read data 0xDEADBEEF, stall stays 0.
- RAM preloaded 0x10/0x11/0x12/0x13 at addr 0..3; 4 back-to-back reads → stall 0, 4 consecutive acks with data 0x10, 0x11, 0x12, 0x13 in order.
- Addr 0x020 holds 0x11223344; write 0x0000AB00 with sel 4'b0010 → stall high 1 cycle, ack 2 edges after accept; readback gives 0x1122AB44.
- Write with sel 4'b0000 to addr 0x020 → ack after 2 edges, o_enA never high, readback unchanged.
- Read accepted, then i_wb_cyc dropped the next cycle → no ack for it; a following new cycle's read is acked normally.
- i_reset asserted during the RMW cycle of a sel 4'b0001 write → o_enA/o_weA drop immediately, o_wb_ack 0, o_wb_stall 0, target word unchanged.
